// File: rtl/multi_edge_debounce_pkg.sv
// Shared constants for the multi-channel key/pin debouncer: edge-select
// encodings, default 50 MHz timing and a width helper.
package multi_edge_debounce_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_H2L  = 2'b01;
  localparam logic [1:0] EDGE_L2H  = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int T100US = 4_999;
  localparam int T20MS  = 1_000_000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Counter width never collapses to zero bits for degenerate lengths.
  function automatic int cnt_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/multi_edge_debounce_channel.sv
// One channel: synchroniser, debounce counter, debounced level and
// registered one-cycle edge pulses gated by the shared ready signal.
module debounce_channel
  import multi_edge_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic gate,
  output logic level,
  output logic h2l,
  output logic l2h
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   h2l_q, h2l_d;
  logic                   l2h_q, l2h_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
    level_d = level_q;
    cnt_d   = cnt_q;
    h2l_d   = 1'b0;
    l2h_d   = 1'b0;
    if (sync_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Level follows even while gated so blanking swallows the change.
      level_d = sync_s;
      cnt_d   = '0;
      h2l_d   = gate & level_q;
      l2h_d   = gate & ~level_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      h2l_q   <= 1'b0;
      l2h_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      h2l_q   <= h2l_d;
      l2h_q   <= l2h_d;
    end
  end

  assign level = level_q;
  assign h2l   = h2l_q;
  assign l2h   = l2h_q;

endmodule

// File: rtl/multi_edge_debounce.sv
// N-channel debounced edge detector with start-up blanking and sticky
// per-channel event flags cleared by software.
module multi_edge_debounce
  import multi_edge_debounce_pkg::*;
#(
  parameter int             N               = 4,
  parameter int             SYNC_STAGES     = 2,
  parameter int             DEBOUNCE_CYCLES = T20MS,
  parameter int             STARTUP_CYCLES  = T100US,
  parameter logic [N-1:0]   IDLE_LEVEL      = {N{1'b1}},
  parameter logic [2*N-1:0] EDGE_SEL        = {N{2'b01}}
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] pin_in,
  input  logic [N-1:0] Evt_Clr,
  output logic         Ready,
  output logic [N-1:0] Level,
  output logic [N-1:0] H2L_Sig,
  output logic [N-1:0] L2H_Sig,
  output logic [N-1:0] Evt_Pend
);

  localparam int SW = cnt_w(STARTUP_CYCLES + 1);
  localparam logic [SW-1:0] ST_MAX = SW'(STARTUP_CYCLES);

  logic [SW-1:0] start_q, start_d;
  logic          ready_q, ready_d;
  logic [N-1:0]  evt_q, evt_d;
  logic [N-1:0]  sel_h2l, sel_l2h;

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL[i])
    ) u_ch (
      .clk  (CLK),
      .rst  (RST),
      .pin  (pin_in[i]),
      .gate (ready_q),
      .level(Level[i]),
      .h2l  (H2L_Sig[i]),
      .l2h  (L2H_Sig[i])
    );
    assign sel_h2l[i] = (EDGE_SEL[2*i +: 2] == EDGE_H2L) || (EDGE_SEL[2*i +: 2] == EDGE_BOTH);
    assign sel_l2h[i] = (EDGE_SEL[2*i +: 2] == EDGE_L2H) || (EDGE_SEL[2*i +: 2] == EDGE_BOTH);
  end

  always_comb begin
    start_d = (start_q == ST_MAX) ? start_q : start_q + SW'(1);
    ready_d = ready_q | (start_q == ST_MAX);
    // Set is ORed after the clear so a same-cycle event is never lost.
    evt_d   = (evt_q & ~Evt_Clr) | (sel_h2l & H2L_Sig) | (sel_l2h & L2H_Sig);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      start_q <= '0;
      ready_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      start_q <= start_d;
      ready_q <= ready_d;
      evt_q   <= evt_d;
    end
  end

  assign Ready    = ready_q;
  assign Evt_Pend = evt_q;

endmodule

// File: tb/tb_multi_edge_debounce.sv
// Bench for multi_edge_debounce: per-cycle scoreboard against a behavioural
// model, a settle/clear vector table and hand sequences for timing corners.
module tb_multi_edge_debounce;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int SU = 9;
  localparam logic [3:0] IDLE = 4'b1111;
  localparam logic [7:0] SEL  = 8'b11_10_01_00;

  logic       clk = 1'b0;
  logic       RST;
  logic [3:0] pin_in, Evt_Clr;
  logic       Ready;
  logic [3:0] Level, H2L_Sig, L2H_Sig, Evt_Pend;

  always #5 clk = ~clk;

  multi_edge_debounce #(
    .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .STARTUP_CYCLES(SU),
    .IDLE_LEVEL(IDLE), .EDGE_SEL(SEL)
  ) dut (
    .CLK(clk), .RST(RST), .pin_in(pin_in), .Evt_Clr(Evt_Clr),
    .Ready(Ready), .Level(Level), .H2L_Sig(H2L_Sig), .L2H_Sig(L2H_Sig),
    .Evt_Pend(Evt_Pend)
  );

  typedef struct packed {
    logic       ready;
    logic [3:0] level, h2l, l2h, pend;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [3:0] pin, clr;
    int         cyc;
    logic       ready;
    logic [3:0] level, pend;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Model state; channel 1 and 3 latch on H2L, channel 2 and 3 on L2H.
  localparam logic [3:0] M_SELH = 4'b1010;
  localparam logic [3:0] M_SELL = 4'b1100;
  logic [3:0] m_s0, m_s1, m_lvl, m_h2l, m_l2h, m_pend;
  int         m_cnt[4];
  int         m_start;
  logic       m_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic [3:0] p, input logic [3:0] c);
    logic [3:0] nl, nh, nu;
    if (r) begin
      m_s0 = IDLE; m_s1 = IDLE; m_lvl = IDLE;
      m_h2l = '0; m_l2h = '0; m_pend = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_start = 0; m_ready = 1'b0;
    end else begin
      m_pend = (m_pend & ~c) | (M_SELH & m_h2l) | (M_SELL & m_l2h);
      nl = m_lvl; nh = '0; nu = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s1[i] == m_lvl[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DB - 1) begin
          nl[i] = m_s1[i];
          m_cnt[i] = 0;
          if (m_ready) begin
            if (m_s1[i]) nu[i] = 1'b1;
            else         nh[i] = 1'b1;
          end
        end else m_cnt[i]++;
      end
      m_lvl = nl; m_h2l = nh; m_l2h = nu;
      if (m_start == SU) m_ready = 1'b1;
      else m_start++;
      m_s1 = m_s0; m_s0 = p;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic [3:0] c);
    obs_t e;
    RST = r; pin_in = p; Evt_Clr = c;
    model(r, p, c);
    e.ready = m_ready; e.level = m_lvl; e.h2l = m_h2l; e.l2h = m_l2h; e.pend = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_ready", 32'(Ready),    32'(e.ready));
    chk("sb_level", 32'(Level),    32'(e.level));
    chk("sb_h2l",   32'(H2L_Sig),  32'(e.h2l));
    chk("sb_l2h",   32'(L2H_Sig),  32'(e.l2h));
    chk("sb_pend",  32'(Evt_Pend), 32'(e.pend));
  endtask

  initial begin
    vec_t tbl[4];
    int   n, at, ph, npc;
    logic saw;
    logic [3:0] c, ph_h, ph_l;

    tbl[0] = '{1'b0, 4'h2, 4'h0, 10, 1'b1, 4'h2, 4'h6};
    tbl[1] = '{1'b0, 4'h2, 4'hF,  1, 1'b1, 4'h2, 4'h0};
    tbl[2] = '{1'b0, 4'h2, 4'h5,  2, 1'b1, 4'h2, 4'h0};
    tbl[3] = '{1'b0, 4'hD, 4'h0, 10, 1'b1, 4'hD, 4'hE};

    RST = 1'b1; pin_in = IDLE; Evt_Clr = '0;
    repeat (3) step(1'b1, IDLE, 4'h0);
    chk("rst_ready", 32'(Ready), 0);
    chk("rst_level", 32'(Level), 32'(IDLE));

    // Blanking: change on ch0 is accepted silently
    saw = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, (e >= 2) ? 4'hE : 4'hF, 4'h0);
      if (H2L_Sig[0]) saw = 1'b1;
      if (e == 6)  chk("blank_level0_pre", 32'(Level[0]), 1);
      if (e == 7)  chk("blank_level0",     32'(Level[0]), 0);
      if (e == 9)  chk("blank_ready_lo",   32'(Ready), 0);
      if (e == 10) chk("blank_ready_hi",   32'(Ready), 1);
    end
    chk("blank_no_h2l", 32'(saw), 0);
    chk("blank_pend",   32'(Evt_Pend), 0);

    // Clean edge on ch1: pulse after edge k+5
    n = 0; at = -1;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 4'hC, 4'h0);
      if (H2L_Sig[1]) begin n++; at = j; end
    end
    chk("clean_h2l_at",    32'(at), 5);
    chk("clean_h2l_count", 32'(n), 1);
    chk("clean_pend1",     32'(Evt_Pend[1]), 1);
    repeat (5) step(1'b0, 4'hC, 4'h0);
    chk("clean_pend_hold", 32'(Evt_Pend[1]), 1);

    // Glitch on ch2: 3 low cycles rejected
    n = 0;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, (j < 3) ? 4'h8 : 4'hC, 4'h0);
      if (H2L_Sig[2] | L2H_Sig[2]) n++;
    end
    chk("glitch_no_pulse", 32'(n), 0);
    chk("glitch_level2",   32'(Level[2]), 1);

    // Exactly 4 low cycles accepted, then the return high is accepted too
    n = 0; at = -1;
    for (int j = 0; j < 14; j++) begin
      step(1'b0, (j < 4) ? 4'h8 : 4'hC, 4'h0);
      if (H2L_Sig[2]) n++;
      if (L2H_Sig[2]) at = j;
      if (j == 6) chk("glitch4_level2", 32'(Level[2]), 0);
      if (j == 8) chk("glitch4_nopend", 32'(Evt_Pend[2]), 0);
    end
    chk("glitch4_h2l_count", 32'(n), 1);
    chk("glitch4_l2h_at",    32'(at), 9);
    chk("glitch4_pend2",     32'(Evt_Pend[2]), 1);

    // Set/clear race on ch3
    ph = 0;
    for (int j = 0; j < 10; j++) begin
      c = (ph == 1 || ph == 2) ? 4'h8 : 4'h0;
      step(1'b0, 4'h4, c);
      case (ph)
        0: if (H2L_Sig[3]) ph = 1;
        1: begin chk("race_set_wins", 32'(Evt_Pend[3]), 1); ph = 2; end
        2: begin chk("race_clear",    32'(Evt_Pend[3]), 0); ph = 3; end
        default: ;
      endcase
    end
    chk("race_done", 32'(ph), 3);

    // Settle / clear / simultaneous-toggle table
    for (int r = 0; r < 4; r++) begin
      npc = 0; ph_h = '0; ph_l = '0;
      for (int k = 0; k < tbl[r].cyc; k++) begin
        step(tbl[r].rst, tbl[r].pin, tbl[r].clr);
        if ((H2L_Sig | L2H_Sig) != 4'h0) begin npc++; ph_h = H2L_Sig; ph_l = L2H_Sig; end
      end
      chk($sformatf("tbl%0d_ready", r), 32'(Ready),    32'(tbl[r].ready));
      chk($sformatf("tbl%0d_level", r), 32'(Level),    32'(tbl[r].level));
      chk($sformatf("tbl%0d_pend", r),  32'(Evt_Pend), 32'(tbl[r].pend));
      if (r == 3) begin
        chk("simul_pulse_cycles", 32'(npc), 1);
        chk("simul_h2l", 32'(ph_h), 32'h2);
        chk("simul_l2h", 32'(ph_l), 32'hD);
      end
    end

    // Reset mid-debounce on ch0, then blanking restarts
    for (int j = 0; j < 4; j++) step(1'b0, 4'hC, 4'h0);
    step(1'b1, 4'hC, 4'h0);
    chk("mid_rst_ready", 32'(Ready),    0);
    chk("mid_rst_level", 32'(Level),    32'hF);
    chk("mid_rst_h2l",   32'(H2L_Sig),  0);
    chk("mid_rst_l2h",   32'(L2H_Sig),  0);
    chk("mid_rst_pend",  32'(Evt_Pend), 0);
    n = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, 4'hC, 4'h0);
      if ((H2L_Sig | L2H_Sig) != 4'h0) n++;
      if (e == 9)  chk("reblank_ready_lo", 32'(Ready), 0);
      if (e == 10) chk("reblank_ready_hi", 32'(Ready), 1);
    end
    chk("reblank_no_pulse", 32'(n), 0);
    chk("reblank_level",    32'(Level), 32'hC);
    chk("reblank_pend",     32'(Evt_Pend), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
